// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and interrupt controller for the 3-stage RV32I pipeline.
// Optional machine timer (mtime/mtimecmp, MTIP) is built when CSR_MTIME_EN is defined.
module csr_irq_sync_cell (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

module csr_irq_unit #(
  parameter int              XLEN        = 32,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_reg_rd,
  input  logic               csr_reg_wr,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [XLEN-1:0]    pc_in,
  input  logic               instr_valid,
  input  logic               is_mret,
  input  logic [NUM_IRQ-1:0] irq_lines,
  output logic               irq_taken,
  output logic               mret_taken,
  output logic [XLEN-1:0]    redirect_pc
);
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [11:0] A_MTIMEL  = 12'h7C0;
  localparam logic [11:0] A_MTIMEH  = 12'h7C1;
  localparam logic [11:0] A_MCMPL   = 12'h7C2;
  localparam logic [11:0] A_MCMPH   = 12'h7C3;

  localparam logic [XLEN-1:0] MIE_MASK =
    XLEN'(((64'd1 << NUM_IRQ) - 64'd1) << 16) | XLEN'(64'h80);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic [NUM_IRQ-1:0] irq_sync;
  logic [XLEN-1:0]    mip, pend, rd_val, wval;
  logic [4:0]         cause;
  logic               wr_en, mtip;
  logic [XLEN-1:0]    tvec_base;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    csr_irq_sync_cell u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (irq_lines[g]),
      .q_o   (irq_sync[g])
    );
  end

`ifdef CSR_MTIME_EN
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        mtip_q;

  assign mtip = mtip_q;
`else
  assign mtip = 1'b0;
`endif

  always_comb begin
    mip    = '0;
    mip[7] = mtip;
    for (int i = 0; i < NUM_IRQ; i++) mip[16+i] = irq_sync[i];
  end

  assign pend = mip & mie_q;

  // Walk from the top down so the lowest-index external line wins; MTIP is the fallback.
  always_comb begin
    cause = 5'd7;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[16+i]) cause = 5'(16 + i);
  end

  assign irq_taken  = mstatus_mie_q & (|pend) & instr_valid & ~is_mret;
  assign mret_taken = is_mret & instr_valid;
  assign tvec_base  = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    redirect_pc = '0;
    if (mret_taken)
      redirect_pc = mepc_q;
    else if (irq_taken)
      redirect_pc = mtvec_q[0] ? tvec_base + (XLEN'(cause) << 2) : tvec_base;
  end

  always_comb begin
    rd_val = '0;
    case (csr_addr)
      A_MSTATUS: begin
        rd_val[3] = mstatus_mie_q;
        rd_val[7] = mstatus_mpie_q;
      end
      A_MIE:    rd_val = mie_q;
      A_MTVEC:  rd_val = mtvec_q;
      A_MEPC:   rd_val = mepc_q;
      A_MCAUSE: rd_val = mcause_q;
      A_MIP:    rd_val = mip;
`ifdef CSR_MTIME_EN
      A_MTIMEL: rd_val = XLEN'(mtime_q[31:0]);
      A_MTIMEH: rd_val = XLEN'(mtime_q[63:32]);
      A_MCMPL:  rd_val = XLEN'(mtimecmp_q[31:0]);
      A_MCMPH:  rd_val = XLEN'(mtimecmp_q[63:32]);
`endif
      default:  rd_val = '0;
    endcase
  end

  assign csr_rdata = csr_reg_rd ? rd_val : '0;

  always_comb begin
    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = rd_val | csr_wdata;
      2'b11:   wval = rd_val & ~csr_wdata;
      default: wval = rd_val;
    endcase
  end

  // A trap or MRET retires the instruction without its CSR side effect.
  assign wr_en = csr_reg_wr & (csr_op != 2'b00) & ~irq_taken & ~mret_taken;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    if (wr_en) begin
      case (csr_addr)
        A_MSTATUS: begin
          mstatus_mie_d  = wval[3];
          mstatus_mpie_d = wval[7];
        end
        A_MIE:    mie_d    = wval & MIE_MASK;
        A_MTVEC:  mtvec_d  = {wval[XLEN-1:2], 1'b0, wval[0]};
        A_MEPC:   mepc_d   = {wval[XLEN-1:2], 2'b00};
        A_MCAUSE: mcause_d = wval;
        default: ;
      endcase
    end
    if (irq_taken) begin
      mepc_d         = {pc_in[XLEN-1:2], 2'b00};
      mcause_d       = {1'b1, (XLEN-1)'(cause)};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end
    if (mret_taken) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

`ifdef CSR_MTIME_EN
  // A software write to either mtime half replaces this cycle's increment.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (wr_en) begin
      case (csr_addr)
        A_MTIMEL: mtime_d           = {mtime_q[63:32], wval[31:0]};
        A_MTIMEH: mtime_d           = {wval[31:0], mtime_q[31:0]};
        A_MCMPL:  mtimecmp_d[31:0]  = wval[31:0];
        A_MCMPH:  mtimecmp_d[63:32] = wval[31:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end
`endif
endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed self-checking bench for csr_irq_unit (timer checks built with CSR_MTIME_EN).
module tb_csr_irq_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        csr_reg_rd = 1'b0, csr_reg_wr = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0, csr_rdata;
  logic [31:0] pc_in = '0;
  logic        instr_valid = 1'b0, is_mret = 1'b0;
  logic [3:0]  irq_lines = '0;
  logic        irq_taken, mret_taken;
  logic [31:0] redirect_pc;

  int n_chk = 0;
  int n_pass = 0;

  csr_irq_unit #(.XLEN(32), .NUM_IRQ(4), .RESET_MTVEC(32'h100)) dut (
    .clk         (clk),
    .reset       (reset),
    .csr_reg_rd  (csr_reg_rd),
    .csr_reg_wr  (csr_reg_wr),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .pc_in       (pc_in),
    .instr_valid (instr_valid),
    .is_mret     (is_mret),
    .irq_lines   (irq_lines),
    .irq_taken   (irq_taken),
    .mret_taken  (mret_taken),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic csr_write(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] d);
    @(negedge clk);
    csr_reg_wr = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = d;
    @(negedge clk);
    csr_reg_wr = 1'b0; csr_op = 2'b00;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] d);
    @(negedge clk);
    csr_reg_rd = 1'b1; csr_addr = addr;
    #1 d = csr_rdata;
    csr_reg_rd = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic [11:0] zaddr [5] = '{12'h300, 12'h304, 12'h341, 12'h342, 12'h344};
    repeat (3) @(negedge clk);
    reset = 1'b1;
    csr_read(12'h305, v);
    n_chk++; if (v !== 32'h100) $display("FAIL reset_mtvec got %h want %h", v, 32'h100); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      csr_read(zaddr[i], v);
      n_chk++; if (v !== 32'h0) $display("FAIL reset_csr_%h got %h want 0", zaddr[i], v); else n_pass++;
    end
    csr_addr = 12'h305; #1;
    n_chk++; if (csr_rdata !== 32'h0) $display("FAIL rdata_no_rd got %h want 0", csr_rdata); else n_pass++;
    n_chk++;
    if (irq_taken !== 1'b0 || mret_taken !== 1'b0 || redirect_pc !== 32'h0)
      $display("FAIL reset_outputs got irq=%b mret=%b pc=%h want 0 0 0", irq_taken, mret_taken, redirect_pc);
    else n_pass++;
  endtask

  task automatic test_bitops;
    logic [31:0] v;
    csr_write(2'b01, 12'h304, 32'h0001_0080);
    csr_write(2'b10, 12'h304, 32'h0002_0000);
    csr_write(2'b11, 12'h304, 32'h0000_0080);
    csr_read(12'h304, v);
    n_chk++; if (v !== 32'h0003_0000) $display("FAIL mie_bitops got %h want %h", v, 32'h0003_0000); else n_pass++;
    csr_write(2'b00, 12'h304, 32'hFFFF_FFFF);
    csr_read(12'h304, v);
    n_chk++; if (v !== 32'h0003_0000) $display("FAIL mie_op00 got %h want %h", v, 32'h0003_0000); else n_pass++;
    csr_write(2'b01, 12'h344, 32'hFFFF_FFFF);
    csr_read(12'h344, v);
    n_chk++; if (v !== 32'h0) $display("FAIL mip_readonly got %h want 0", v); else n_pass++;
    csr_write(2'b01, 12'h123, 32'hDEAD_BEEF);
    csr_read(12'h123, v);
    n_chk++; if (v !== 32'h0) $display("FAIL unimpl got %h want 0", v); else n_pass++;
    csr_write(2'b01, 12'h305, 32'h0000_0203);
    csr_read(12'h305, v);
    n_chk++; if (v !== 32'h0000_0201) $display("FAIL mtvec_mode got %h want %h", v, 32'h201); else n_pass++;
    csr_write(2'b01, 12'h341, 32'h0000_0047);
    csr_read(12'h341, v);
    n_chk++; if (v !== 32'h0000_0044) $display("FAIL mepc_align got %h want %h", v, 32'h44); else n_pass++;
  endtask

  task automatic test_direct_trap;
    logic [31:0] v;
    csr_write(2'b01, 12'h305, 32'h200);
    csr_write(2'b01, 12'h304, 32'h0001_0000);
    csr_write(2'b10, 12'h300, 32'h8);
    @(negedge clk);
    irq_lines = 4'b0001; instr_valid = 1'b1; pc_in = 32'h40;
    @(negedge clk);
    n_chk++; if (irq_taken !== 1'b0) $display("FAIL sync_cycle1 got %b want 0", irq_taken); else n_pass++;
    @(negedge clk);
    n_chk++;
    if (irq_taken !== 1'b1 || redirect_pc !== 32'h200)
      $display("FAIL direct_trap got irq=%b pc=%h want 1 %h", irq_taken, redirect_pc, 32'h200);
    else n_pass++;
    @(negedge clk);
    n_chk++; if (irq_taken !== 1'b0) $display("FAIL trap_masks_mie got %b want 0", irq_taken); else n_pass++;
    instr_valid = 1'b0;
    csr_read(12'h341, v);
    n_chk++; if (v !== 32'h40) $display("FAIL direct_mepc got %h want %h", v, 32'h40); else n_pass++;
    csr_read(12'h342, v);
    n_chk++; if (v !== 32'h8000_0010) $display("FAIL direct_mcause got %h want %h", v, 32'h8000_0010); else n_pass++;
    csr_read(12'h300, v);
    n_chk++; if (v !== 32'h80) $display("FAIL direct_mstatus got %h want %h", v, 32'h80); else n_pass++;
    csr_read(12'h344, v);
    n_chk++; if (v !== 32'h0001_0000) $display("FAIL direct_mip got %h want %h", v, 32'h0001_0000); else n_pass++;
  endtask

  task automatic test_vectored;
    logic [31:0] v;
    csr_write(2'b01, 12'h305, 32'h201);
    csr_write(2'b01, 12'h304, 32'h0005_0000);
    irq_lines = 4'b0101;
    repeat (2) @(negedge clk);
    csr_write(2'b10, 12'h300, 32'h8);
    instr_valid = 1'b1; pc_in = 32'h80;
    csr_reg_wr = 1'b1; csr_op = 2'b01; csr_addr = 12'h304; csr_wdata = 32'h0;
    #1;
    n_chk++;
    if (irq_taken !== 1'b1 || redirect_pc !== 32'h240)
      $display("FAIL vectored_line0 got irq=%b pc=%h want 1 %h", irq_taken, redirect_pc, 32'h240);
    else n_pass++;
    @(negedge clk);
    csr_reg_wr = 1'b0; csr_op = 2'b00; instr_valid = 1'b0;
    csr_read(12'h304, v);
    n_chk++; if (v !== 32'h0005_0000) $display("FAIL trap_write_suppressed got %h want %h", v, 32'h0005_0000); else n_pass++;
    csr_read(12'h341, v);
    n_chk++; if (v !== 32'h80) $display("FAIL vectored_mepc got %h want %h", v, 32'h80); else n_pass++;
    csr_read(12'h342, v);
    n_chk++; if (v !== 32'h8000_0010) $display("FAIL vectored_mcause got %h want %h", v, 32'h8000_0010); else n_pass++;
    irq_lines = 4'b0100;
    repeat (2) @(negedge clk);
    csr_write(2'b10, 12'h300, 32'h8);
    instr_valid = 1'b1;
    #1;
    n_chk++;
    if (irq_taken !== 1'b1 || redirect_pc !== 32'h248)
      $display("FAIL vectored_line2 got irq=%b pc=%h want 1 %h", irq_taken, redirect_pc, 32'h248);
    else n_pass++;
    instr_valid = 1'b0;
    #1;
    n_chk++; if (irq_taken !== 1'b0) $display("FAIL no_valid_no_trap got %b want 0", irq_taken); else n_pass++;
    irq_lines = 4'b0000;
    csr_write(2'b01, 12'h304, 32'h0);
  endtask

  task automatic test_mret;
    logic [31:0] v;
    csr_write(2'b01, 12'h341, 32'h44);
    csr_write(2'b11, 12'h300, 32'h8);
    csr_read(12'h300, v);
    n_chk++; if (v !== 32'h80) $display("FAIL pre_mret_mstatus got %h want %h", v, 32'h80); else n_pass++;
    @(negedge clk);
    is_mret = 1'b1; instr_valid = 1'b0;
    #1;
    n_chk++;
    if (mret_taken !== 1'b0 || redirect_pc !== 32'h0)
      $display("FAIL mret_bubble got mret=%b pc=%h want 0 0", mret_taken, redirect_pc);
    else n_pass++;
    instr_valid = 1'b1;
    csr_reg_wr = 1'b1; csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'h100;
    #1;
    n_chk++;
    if (mret_taken !== 1'b1 || irq_taken !== 1'b0 || redirect_pc !== 32'h44)
      $display("FAIL mret_redirect got mret=%b irq=%b pc=%h want 1 0 %h", mret_taken, irq_taken, redirect_pc, 32'h44);
    else n_pass++;
    @(negedge clk);
    is_mret = 1'b0; instr_valid = 1'b0; csr_reg_wr = 1'b0; csr_op = 2'b00;
    csr_read(12'h300, v);
    n_chk++; if (v !== 32'h88) $display("FAIL mret_mstatus got %h want %h", v, 32'h88); else n_pass++;
    csr_read(12'h341, v);
    n_chk++; if (v !== 32'h44) $display("FAIL mret_write_dropped got %h want %h", v, 32'h44); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    csr_write(2'b01, 12'h304, 32'h0001_0000);
    @(negedge clk);
    reset = 1'b0;
    csr_read(12'h305, v);
    n_chk++; if (v !== 32'h100) $display("FAIL midreset_mtvec got %h want %h", v, 32'h100); else n_pass++;
    csr_read(12'h341, v);
    n_chk++; if (v !== 32'h0) $display("FAIL midreset_mepc got %h want 0", v); else n_pass++;
    csr_read(12'h300, v);
    n_chk++; if (v !== 32'h0) $display("FAIL midreset_mstatus got %h want 0", v); else n_pass++;
    csr_read(12'h304, v);
    n_chk++; if (v !== 32'h0) $display("FAIL midreset_mie got %h want 0", v); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef CSR_MTIME_EN
  task automatic test_timer;
    logic [31:0] v;
    int hit;
    hit = -1;
    csr_write(2'b01, 12'h304, 32'h80);
    csr_write(2'b10, 12'h300, 32'h8);
    csr_write(2'b01, 12'h7C2, 32'd20);
    csr_write(2'b01, 12'h7C3, 32'd0);
    csr_write(2'b01, 12'h7C0, 32'd0);
    instr_valid = 1'b1; pc_in = 32'h300;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (irq_taken) begin
        hit = k;
        csr_reg_rd = 1'b1; csr_addr = 12'h7C0;
        #1 v = csr_rdata;
        csr_reg_rd = 1'b0;
        break;
      end
      @(negedge clk);
    end
    n_chk++; if (hit != 21) $display("FAIL timer_latency got %0d want 21", hit); else n_pass++;
    n_chk++; if (hit >= 0 && v !== 32'd21) $display("FAIL timer_mtime got %0d want 21", v); else n_pass++;
    @(negedge clk);
    instr_valid = 1'b0;
    csr_read(12'h342, v);
    n_chk++; if (v !== 32'h8000_0007) $display("FAIL timer_mcause got %h want %h", v, 32'h8000_0007); else n_pass++;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    csr_read(12'h7C0, v);
    n_chk++; if (v !== 32'h0) $display("FAIL timer_reset_mtime got %h want 0", v); else n_pass++;
    csr_read(12'h7C2, v);
    n_chk++; if (v !== 32'hFFFF_FFFF) $display("FAIL timer_reset_cmplo got %h want ffffffff", v); else n_pass++;
    csr_read(12'h7C3, v);
    n_chk++; if (v !== 32'hFFFF_FFFF) $display("FAIL timer_reset_cmphi got %h want ffffffff", v); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask
`else
  task automatic test_timer;
    logic [31:0] v;
    csr_write(2'b01, 12'h7C2, 32'd5);
    csr_read(12'h7C2, v);
    n_chk++; if (v !== 32'h0) $display("FAIL notimer_unimpl got %h want 0", v); else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_bitops;
    test_direct_trap;
    test_vectored;
    test_mret;
    test_reset_mid;
    test_timer;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
